bus_fabric: RTL and testbench

BUS_FABRIC -- requirements
Module: bus_fabric

---
 rtl/bus_pkg.sv | 18 +
 rtl/bus_arbiter.sv | 38 +++
 rtl/bus_fabric.sv | 112 +++++++++++
 tb/tb_bus_fabric.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus fabric constants: default widths, master/slave counts, owner
// encoding and the position of the slave-index field in the word address.
package bus_pkg;
  localparam int ADDR_W_DEF = 30;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_M      = 4;
  localparam int NUM_S      = 8;
  localparam int OWNER_W    = $clog2(NUM_M);
  localparam int SEL_W      = $clog2(NUM_S);

  typedef logic [OWNER_W-1:0] owner_t;
  localparam owner_t OWNER_RST = '0;

  // Slave index occupies the top SEL_W bits of the word address.
  function automatic logic [SEL_W-1:0] slave_sel(input logic [ADDR_W_DEF-1:0] addr);
    return addr[ADDR_W_DEF-1 -: SEL_W];
  endfunction
endpackage

// File: rtl/bus_arbiter.sv
// Rotating-priority arbiter: owner keeps the bus while requesting; on release
// the next requester after the owner (mod NUM_M) wins on the following edge.
module bus_arbiter
  import bus_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [NUM_M-1:0] req_n_i,
  output logic [NUM_M-1:0] grnt_n_o,
  output owner_t           owner_o
);
  owner_t owner_q, owner_d;
  owner_t cand;
  logic   found;

  always_comb begin
    owner_d = owner_q;
    cand    = '0;
    found   = 1'b0;
    if (req_n_i[owner_q]) begin
      for (int i = 1; i < NUM_M; i++) begin
        cand = owner_q + OWNER_W'(i);
        if (!found && !req_n_i[cand]) begin
          owner_d = cand;
          found   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) owner_q <= OWNER_RST;
    else       owner_q <= owner_d;
  end

  assign grnt_n_o = ~(NUM_M'(1) << owner_q);
  assign owner_o  = owner_q;
endmodule

// File: rtl/bus_fabric.sv
// Four-master / eight-slave shared bus: arbiter picks the owner, the owner's
// signals drive the slave bus, top address bits select the slave.
// Build option BUS_CS_AS_GATE_EN: chip selects qualified by s_as_.
module bus_fabric
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req_,
  input  logic              m1_req_,
  input  logic              m2_req_,
  input  logic              m3_req_,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_as_,
  input  logic              m0_rw,
  input  logic [DATA_W-1:0] m0_wr_data,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_as_,
  input  logic              m1_rw,
  input  logic [DATA_W-1:0] m1_wr_data,
  input  logic [ADDR_W-1:0] m2_addr,
  input  logic              m2_as_,
  input  logic              m2_rw,
  input  logic [DATA_W-1:0] m2_wr_data,
  input  logic [ADDR_W-1:0] m3_addr,
  input  logic              m3_as_,
  input  logic              m3_rw,
  input  logic [DATA_W-1:0] m3_wr_data,
  input  logic [DATA_W-1:0] s0_rd_data,
  input  logic              s0_rdy_,
  input  logic [DATA_W-1:0] s1_rd_data,
  input  logic              s1_rdy_,
  input  logic [DATA_W-1:0] s2_rd_data,
  input  logic              s2_rdy_,
  input  logic [DATA_W-1:0] s3_rd_data,
  input  logic              s3_rdy_,
  input  logic [DATA_W-1:0] s4_rd_data,
  input  logic              s4_rdy_,
  input  logic [DATA_W-1:0] s5_rd_data,
  input  logic              s5_rdy_,
  input  logic [DATA_W-1:0] s6_rd_data,
  input  logic              s6_rdy_,
  input  logic [DATA_W-1:0] s7_rd_data,
  input  logic              s7_rdy_,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_as_,
  output logic              s_rw,
  output logic [DATA_W-1:0] s_wr_data,
  output logic              s0_cs_,
  output logic              s1_cs_,
  output logic              s2_cs_,
  output logic              s3_cs_,
  output logic              s4_cs_,
  output logic              s5_cs_,
  output logic              s6_cs_,
  output logic              s7_cs_,
  output logic [DATA_W-1:0] m_rd_data,
  output logic              m_rdy_,
  output logic              m0_grnt_,
  output logic              m1_grnt_,
  output logic              m2_grnt_,
  output logic              m3_grnt_
);
  logic [NUM_M-1:0][ADDR_W-1:0] m_addr_a;
  logic [NUM_M-1:0][DATA_W-1:0] m_wdat_a;
  logic [NUM_M-1:0]             m_as_a, m_rw_a, req_n, grnt_n;
  logic [NUM_S-1:0][DATA_W-1:0] s_rdat_a;
  logic [NUM_S-1:0]             s_rdy_a, cs_n;
  logic [SEL_W-1:0]             sel;
  owner_t                       owner;

  assign m_addr_a = {m3_addr, m2_addr, m1_addr, m0_addr};
  assign m_wdat_a = {m3_wr_data, m2_wr_data, m1_wr_data, m0_wr_data};
  assign m_as_a   = {m3_as_, m2_as_, m1_as_, m0_as_};
  assign m_rw_a   = {m3_rw, m2_rw, m1_rw, m0_rw};
  assign req_n    = {m3_req_, m2_req_, m1_req_, m0_req_};
  assign s_rdat_a = {s7_rd_data, s6_rd_data, s5_rd_data, s4_rd_data,
                     s3_rd_data, s2_rd_data, s1_rd_data, s0_rd_data};
  assign s_rdy_a  = {s7_rdy_, s6_rdy_, s5_rdy_, s4_rdy_,
                     s3_rdy_, s2_rdy_, s1_rdy_, s0_rdy_};

  bus_arbiter u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_n_i  (req_n),
    .grnt_n_o (grnt_n),
    .owner_o  (owner)
  );

  assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt_n;

  assign s_addr    = m_addr_a[owner];
  assign s_as_     = m_as_a[owner];
  assign s_rw      = m_rw_a[owner];
  assign s_wr_data = m_wdat_a[owner];

  assign sel = s_addr[ADDR_W-1 -: SEL_W];

`ifdef BUS_CS_AS_GATE_EN
  assign cs_n = s_as_ ? '1 : ~(NUM_S'(1) << sel);
`else
  assign cs_n = ~(NUM_S'(1) << sel);
`endif

  assign {s7_cs_, s6_cs_, s5_cs_, s4_cs_, s3_cs_, s2_cs_, s1_cs_, s0_cs_} = cs_n;

  assign m_rd_data = s_rdat_a[sel];
  assign m_rdy_    = s_rdy_a[sel];
endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: reset, grant rotation, parking, reset
// override, address decode and optional as_-gated chip selects.
module tb_bus_fabric;
  localparam int AW = 30;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req_n = 4'hF;
  logic [3:0][AW-1:0] maddr;
  logic [3:0][DW-1:0] mwd;
  logic [3:0] mas = 4'h0;
  logic [7:0][DW-1:0] srd;
  logic [7:0] srdy = 8'hFD;

  logic [AW-1:0] s_addr;
  logic s_as_, s_rw, m_rdy_;
  logic [DW-1:0] s_wr_data, m_rd_data;
  logic s0_cs_, s1_cs_, s2_cs_, s3_cs_, s4_cs_, s5_cs_, s6_cs_, s7_cs_;
  logic m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  wire [3:0] grnt = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};
  wire [7:0] cs = {s7_cs_, s6_cs_, s5_cs_, s4_cs_, s3_cs_, s2_cs_, s1_cs_, s0_cs_};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_fabric dut (
    .clk(clk), .reset(reset),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .m0_addr(maddr[0]), .m0_as_(mas[0]), .m0_rw(1'b0), .m0_wr_data(mwd[0]),
    .m1_addr(maddr[1]), .m1_as_(mas[1]), .m1_rw(1'b1), .m1_wr_data(mwd[1]),
    .m2_addr(maddr[2]), .m2_as_(mas[2]), .m2_rw(1'b0), .m2_wr_data(mwd[2]),
    .m3_addr(maddr[3]), .m3_as_(mas[3]), .m3_rw(1'b1), .m3_wr_data(mwd[3]),
    .s0_rd_data(srd[0]), .s0_rdy_(srdy[0]), .s1_rd_data(srd[1]), .s1_rdy_(srdy[1]),
    .s2_rd_data(srd[2]), .s2_rdy_(srdy[2]), .s3_rd_data(srd[3]), .s3_rdy_(srdy[3]),
    .s4_rd_data(srd[4]), .s4_rdy_(srdy[4]), .s5_rd_data(srd[5]), .s5_rdy_(srdy[5]),
    .s6_rd_data(srd[6]), .s6_rdy_(srdy[6]), .s7_rd_data(srd[7]), .s7_rdy_(srdy[7]),
    .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data),
    .s0_cs_(s0_cs_), .s1_cs_(s1_cs_), .s2_cs_(s2_cs_), .s3_cs_(s3_cs_),
    .s4_cs_(s4_cs_), .s5_cs_(s5_cs_), .s6_cs_(s6_cs_), .s7_cs_(s7_cs_),
    .m_rd_data(m_rd_data), .m_rdy_(m_rdy_),
    .m0_grnt_(m0_grnt_), .m1_grnt_(m1_grnt_), .m2_grnt_(m2_grnt_), .m3_grnt_(m3_grnt_)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_grnt(input string nm, input logic [3:0] exp);
    checks++;
    if (grnt !== exp) begin
      errors++;
      $display("FAIL %s grnt got %b want %b", nm, grnt, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_n = 4'hF;
    tick(); tick();
    chk_grnt("reset_grnt", 4'b1110);
    checks++;
    if (s_wr_data !== 32'h1) begin errors++; $display("FAIL reset_wdata got %h want 1", s_wr_data); end
    checks++;
    if (cs !== 8'hFE) begin errors++; $display("FAIL reset_cs got %h want fe", cs); end
    checks++;
    if (m_rd_data !== 32'h8) begin errors++; $display("FAIL reset_rdata got %h want 8", m_rd_data); end
    checks++;
    if (m_rdy_ !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", m_rdy_); end
  endtask

  task automatic test_grant_m1();
    reset = 1'b0; req_n = 4'b1101;
    #1;
    chk_grnt("m1_before_edge", 4'b1110);
    tick();
    chk_grnt("m1_grnt", 4'b1101);
    checks++;
    if (s_wr_data !== 32'h2) begin errors++; $display("FAIL m1_wdata got %h want 2", s_wr_data); end
    checks++;
    if (cs !== 8'hFD) begin errors++; $display("FAIL m1_cs got %h want fd", cs); end
    checks++;
    if (m_rd_data !== 32'h1) begin errors++; $display("FAIL m1_rdata got %h want 1", m_rd_data); end
    checks++;
    if (m_rdy_ !== 1'b0 || s_rw !== 1'b1) begin
      errors++; $display("FAIL m1_rdy_rw got %b%b want 01", m_rdy_, s_rw);
    end
  endtask

  task automatic test_rotate();
    req_n = 4'b0001;
    tick(); tick();
    chk_grnt("rot_hold_m1", 4'b1101);
    req_n = 4'b0011;
    #1;
    chk_grnt("rot_latency", 4'b1101);
    tick();
    chk_grnt("rot_m2", 4'b1011);
    req_n = 4'b0111;
    tick();
    chk_grnt("rot_m3", 4'b0111);
    req_n = 4'b1110;
    tick();
    chk_grnt("rot_m0", 4'b1110);
    // m1 idle: priority from owner 0 must skip to m2
    req_n = 4'b0011;
    tick();
    chk_grnt("rot_skip_m2", 4'b1011);
  endtask

  task automatic test_park();
    req_n = 4'b0111;
    tick();
    chk_grnt("park_get_m3", 4'b0111);
    req_n = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_grnt("park_grnt", 4'b0111);
      checks++;
      if (cs !== 8'hF7 || m_rd_data !== 32'h3 || s_wr_data !== 32'h4) begin
        errors++;
        $display("FAIL park_outputs cs %h rd %h wd %h want f7 3 4", cs, m_rd_data, s_wr_data);
      end
    end
    // wrap: owner 3 releases, m1 and m2 request -> m1 comes first after m0
    req_n = 4'b1001;
    tick();
    chk_grnt("wrap_m1", 4'b1101);
  endtask

  task automatic test_reset_override();
    req_n = 4'b0111;
    tick();
    chk_grnt("ovr_m3", 4'b0111);
    reset = 1'b1; req_n = 4'b0101;
    tick();
    chk_grnt("ovr_reset", 4'b1110);
    checks++;
    if (s_wr_data !== 32'h1 || cs !== 8'hFE) begin
      errors++; $display("FAIL ovr_outputs wd %h cs %h want 1 fe", s_wr_data, cs);
    end
    reset = 1'b0; req_n = 4'hF;
    tick();
  endtask

  task automatic test_cs_gate();
    mas[0] = 1'b1;
    #1;
    checks++;
`ifdef BUS_CS_AS_GATE_EN
    if (cs !== 8'hFF) begin errors++; $display("FAIL gate_as_high got %h want ff", cs); end
`else
    if (cs !== 8'hFE) begin errors++; $display("FAIL gate_as_high got %h want fe", cs); end
`endif
    mas[0] = 1'b0;
    maddr[0] = AW'(7) << 27;
    #1;
    checks++;
    if (cs !== 8'h7F || m_rd_data !== 32'h7) begin
      errors++; $display("FAIL gate_as_low cs %h rd %h want 7f 7", cs, m_rd_data);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      maddr[i] = AW'(i) << 27;
      mwd[i]   = DW'(i + 1);
    end
    for (int k = 0; k < 8; k++) srd[k] = (k == 0) ? 32'h8 : DW'(k);
    @(negedge clk);
    test_reset();
    test_grant_m1();
    test_rotate();
    test_park();
    test_reset_override();
    test_cs_gate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
